// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: frame geometry, special scan codes, FIFO entry layout.
package ps2_pkg;
  localparam int         PS2_FRAME_LEN = 11;
  localparam logic [7:0] PS2_BREAK     = 8'hF0;
  localparam logic [7:0] PS2_EXT       = 8'hE0;

  typedef struct packed {
    logic       pressed;
    logic [7:0] code;
  } ps2_entry_t;
endpackage

// File: rtl/ps2_rx_sync_fifo.sv
// Single-clock FIFO with registered storage; a push into a full FIFO is taken when a pop
// happens in the same cycle. Head entry is read combinationally.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic         accepted
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW:0]             wp, rp;
  logic                    do_pop;

  assign empty    = (wp == rp);
  assign full     = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign accepted = push && (!full || do_pop);
  assign dout     = mem[rp[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      mem <= '0;
    end else begin
      if (accepted) begin
        mem[wp[AW-1:0]] <= din;
        wp              <= wp + 1'b1;
      end
      if (do_pop) rp <= rp + 1'b1;
    end
  end
endmodule

// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: synchronizes the line, deframes scan codes, folds F0 into a
// break flag and queues {pressed, code}. Define PS2_PARITY_CHECK_EN to reject bad parity.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       code_ready,
  output logic       code_valid,
  output logic [7:0] code,
  output logic       pressed,
  output logic [7:0] key_count,
  output logic       overflow
);
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [2:0]    cs, ds;
  logic          fall;
  logic [3:0]    bitcnt;
  logic [9:0]    sr;
  logic [10:0]   frame_n;
  logic          accept;
  logic [TW-1:0] tcnt;
  logic [7:0]    byte_q;
  logic          byte_vld, brk;
  logic          push, empty, full, accepted;
  ps2_entry_t    din, head;

  // cs[2] is the oldest sample: high there and low one flop earlier is a falling edge
  assign fall    = cs[2] & ~cs[1];
  assign frame_n = {ds[1], sr};
  assign accept  = !frame_n[0] && frame_n[10] && (!PAR_EN || ^frame_n[9:1]);

  assign push        = byte_vld && (byte_q != PS2_BREAK);
  assign din.pressed = !brk;
  assign din.code    = byte_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs        <= '1;
      ds        <= '1;
      bitcnt    <= '0;
      sr        <= '0;
      tcnt      <= '0;
      byte_q    <= '0;
      byte_vld  <= 1'b0;
      brk       <= 1'b0;
      key_count <= '0;
      overflow  <= 1'b0;
    end else begin
      cs       <= {cs[1:0], ps2_clk};
      ds       <= {ds[1:0], ps2_data};
      byte_vld <= 1'b0;

      if (fall) begin
        tcnt <= '0;
        sr   <= {ds[1], sr[9:1]};
        if (bitcnt == 4'(PS2_FRAME_LEN - 1)) begin
          bitcnt   <= '0;
          byte_q   <= frame_n[8:1];
          byte_vld <= accept;
        end else begin
          bitcnt <= bitcnt + 1'b1;
        end
      end else if (bitcnt != '0) begin
        if (tcnt == TW'(TIMEOUT - 1)) begin
          bitcnt <= '0;
          tcnt   <= '0;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end else begin
        tcnt <= '0;
      end

      // break prefix is consumed by the next code whether or not the FIFO takes it
      if (byte_vld) brk <= (byte_q == PS2_BREAK);
      if (push && !accepted) overflow <= 1'b1;
      if (accepted && !brk) key_count <= key_count + 1'b1;
    end
  end

  sync_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(ps2_entry_t))) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .din      (din),
    .pop      (code_ready),
    .dout     (head),
    .full     (full),
    .empty    (empty),
    .accepted (accepted)
  );

  assign code_valid = !empty;
  assign code       = head.code;
  assign pressed    = head.pressed;
endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: frames driven bit by bit, head entries checked and popped.
module tb_ps2_rx;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       code_ready = 1'b0;
  logic       code_valid;
  logic [7:0] code;
  logic       pressed;
  logic [7:0] key_count;
  logic       overflow;

  int errs = 0;
  int checks = 0;
  int kc_exp = 0;

  ps2_rx #(.FIFO_DEPTH(8), .TIMEOUT(200)) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .code_ready (code_ready),
    .code_valid (code_valid),
    .code       (code),
    .pressed    (pressed),
    .key_count  (key_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    ticks(5);
    ps2_clk = 1'b0;
    ticks(10);
    ps2_clk = 1'b1;
    ticks(5);
  endtask

  // nbits < 11 sends a truncated frame
  task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(f[i]);
    ps2_data = 1'b1;
    ticks(10);
  endtask

  task automatic pop_one();
    @(negedge clk) code_ready = 1'b1;
    @(negedge clk) code_ready = 1'b0;
  endtask

  task automatic expect_head(input string tag, input logic [7:0] c, input logic p);
    @(negedge clk);
    chk({tag, "_valid"}, code_valid, 1'b1);
    chk({tag, "_code"}, code, c);
    chk({tag, "_pressed"}, pressed, p);
    pop_one();
  endtask

  task automatic expect_empty(input string tag);
    @(negedge clk);
    chk({tag, "_empty"}, code_valid, 1'b0);
  endtask

  initial begin
    ticks(3);
    @(negedge clk);
    chk("rst_valid", code_valid, 1'b0);
    chk("rst_code", code, 8'h00);
    chk("rst_pressed", pressed, 1'b0);
    chk("rst_kc", key_count, 8'h00);
    chk("rst_ovf", overflow, 1'b0);
    rst = 1'b0;
    ticks(3);

    // single make code
    send_frame(8'h1C, 1'b0, 11);
    kc_exp++;
    @(negedge clk);
    chk("make_kc", key_count, kc_exp);
    expect_head("make", 8'h1C, 1'b1);
    expect_empty("make");

    // break sequence F0 1C -> one release entry
    send_frame(8'hF0, 1'b0, 11);
    expect_empty("brk_f0");
    send_frame(8'h1C, 1'b0, 11);
    @(negedge clk);
    chk("brk_kc", key_count, kc_exp);
    expect_head("brk", 8'h1C, 1'b0);
    expect_empty("brk");

    // E0 is an ordinary code
    send_frame(8'hE0, 1'b0, 11);
    kc_exp++;
    expect_head("ext", 8'hE0, 1'b1);
    @(negedge clk);
    chk("ext_kc", key_count, kc_exp);

    // nine makes into an 8-deep FIFO with no pops
    for (int i = 0; i < 9; i++) send_frame(8'h10 + 8'(i), 1'b0, 11);
    kc_exp += 8;
    @(negedge clk);
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_kc", key_count, kc_exp);
    for (int i = 0; i < 8; i++) expect_head("ovf_order", 8'h10 + 8'(i), 1'b1);
    expect_empty("ovf");

    // truncated frame abandoned by timeout
    send_frame(8'hAA, 1'b0, 5);
    ticks(300);
    send_frame(8'h32, 1'b0, 11);
    kc_exp++;
    expect_head("tmo", 8'h32, 1'b1);
    expect_empty("tmo");

    // bad parity
    send_frame(8'h1C, 1'b1, 11);
`ifdef PS2_PARITY_CHECK_EN
    expect_empty("par_drop");
`else
    kc_exp++;
    expect_head("par_keep", 8'h1C, 1'b1);
`endif
    @(negedge clk);
    chk("par_kc", key_count, kc_exp);

    // reset mid-frame after start + 4 data bits
    send_frame(8'h3B, 1'b0, 5);
    @(negedge clk) rst = 1'b1;
    ticks(2);
    @(negedge clk);
    chk("mrst_valid", code_valid, 1'b0);
    chk("mrst_code", code, 8'h00);
    chk("mrst_pressed", pressed, 1'b0);
    chk("mrst_kc", key_count, 8'h00);
    chk("mrst_ovf", overflow, 1'b0);
    rst = 1'b0;
    ticks(3);
    send_frame(8'h45, 1'b0, 11);
    @(negedge clk);
    chk("mrst_kc_after", key_count, 8'h01);
    expect_head("mrst", 8'h45, 1'b1);
    expect_empty("mrst");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/ps2_rx.md
PS2_RX -- requirements
Module: ps2_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, 8, scan-code FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter TIMEOUT, 50000, idle clk cycles without a ps2_clk falling edge before a partial frame is aborted.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port ps2_clk  input  1  raw keyboard clock (asynchronous).
REQ-006 SHALL have port ps2_data  input  1  raw keyboard data (asynchronous).
REQ-007 SHALL have port code_ready  input  1  downstream (segment display path) accepts head entry.
REQ-008 SHALL have port code_valid  output  1  FIFO non-empty.
REQ-009 SHALL have port code  output  8  head scan code; nibbles feed the hex segment decoders.
REQ-010 SHALL have port pressed  output  1  head entry: 1 = make, 0 = break.
REQ-011 SHALL have port key_count  output  8  count of make codes pushed, wraps.
REQ-012 SHALL have port overflow  output  1  sticky: a frame was dropped because the FIFO was full.

Function
REQ-013 SHALL pass ps2_clk and ps2_data through 3-flop synchronizers; a sample event SHALL occur when the sync history shows ps2_clk high then low.
REQ-014 SHALL capture one bit per sample event into an 11-bit frame: start(0), 8 data bits LSB first, odd parity, stop(1); bit counter 0..10.
REQ-015 SHALL accept a frame at the 11th sample when start==0 and stop==1; otherwise discard silently; counter returns to 0 either way.
REQ-016 SHALL abort a partial frame (counter to 0, no push) when TIMEOUT cycles elapse with counter!=0 and no sample event.
REQ-017 SHALL NOT push an accepted byte of 8'hF0; it SHALL set break_pending instead.
REQ-018 SHALL push any other accepted byte with pressed = !break_pending, then clear break_pending; 8'hE0 is pushed as an ordinary code.
REQ-019 SHALL push in the cycle after the 11th sample event (2 clk after the synchronized edge is detected at the third flop).
REQ-020 SHALL drop a push when FIFO is full and no pop occurs in the same cycle; the drop SHALL set overflow; break_pending is still cleared.
REQ-021 SHALL allow simultaneous push and pop when full; the count stays unchanged and nothing is dropped.
REQ-022 SHALL pop when code_valid && code_ready; code and pressed SHALL hold stable while code_valid && !code_ready.
REQ-023 SHALL show the head entry on code/pressed combinationally from FIFO storage; code/pressed are don't-care when code_valid==0.
REQ-024 SHALL increment key_count by 1 on every successful push with pressed==1; 8'hFF wraps to 8'h00.

Reset
REQ-025 SHALL on rst clear: FIFO pointers (code_valid=0), code=0, pressed=0, key_count=0, overflow=0, break_pending=0, bit counter=0, timeout counter=0, synchronizers to all-ones.
REQ-026 SHALL abandon any frame in progress when rst is asserted mid-frame; after release, reception restarts at the next start bit.

Configuration
REQ-027 SHALL, with PS2_PARITY_CHECK_EN defined, additionally require odd parity over data+parity for acceptance; a failing frame is discarded.
REQ-028 SHALL, without PS2_PARITY_CHECK_EN, ignore the parity bit entirely.

Structure
REQ-029 SHALL take from shared package ps2_pkg: frame length 11, PS2_BREAK = 8'hF0, PS2_EXT = 8'hE0, and the FIFO entry type {pressed, code[7:0]}.
REQ-030 SHALL instantiate FIFO storage as sub-module sync_fifo (parameterized depth/width, full/empty, same-cycle push+pop when full).

Verification
REQ-031 SHALL cover: frame 8'h1C (odd parity ok), code_ready=1 -> one entry code=8'h1C, pressed=1, key_count=1.
REQ-032 SHALL cover: frames F0 then 1C -> exactly one entry code=8'h1C, pressed=0; key_count unchanged.
REQ-033 SHALL cover: code_ready=0, 9 valid make frames (FIFO_DEPTH=8) -> 8 entries held in order, overflow=1, key_count=8.
REQ-034 SHALL cover: 5 ps2_clk edges then idle > TIMEOUT cycles, then full frame 8'h32 -> single entry 8'h32.
REQ-035 SHALL cover: frame 8'h1C with wrong parity -> dropped with PS2_PARITY_CHECK_EN, pushed without.
REQ-036 SHALL cover: rst asserted after bit 4 of a frame, then a clean frame 8'h45 -> only 8'h45 received; all outputs zero during reset.
